// File: rtl/mdu_iter_if.sv
// Issue/result handshake bundle between the execute stage and the iterative MDU.
// The slave side is the MDU itself; the master side is the issuing pipeline stage.
interface mdu_iter_if #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [DATAWIDTH-1:0]  in_a;
  logic [DATAWIDTH-1:0]  in_b;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  res_valid;
  logic                  res_ready;
  logic [ADDR_WIDTH-1:0] res_rd;
  logic [DATAWIDTH-1:0]  res_data;

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, res_ready,
    input  in_ready, res_valid, res_rd, res_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, res_ready,
    output in_ready, res_valid, res_rd, res_data
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a single sign-fixup cycle at the end.
module mdu_iter #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] busy_rd,
  mdu_iter_if.slave             bus
);
  localparam int DW = DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  neg_q, neg_d;
  logic                  a_neg_q, a_neg_d;
  logic [DW-1:0]         opnd_q, opnd_d;
  logic [2*DW-1:0]       acc_q, acc_d;
  logic [DW-1:0]         res_q, res_d;

  logic            is_div, a_signed, b_signed, a_sign, b_sign;
  logic            div_zero, div_ovf, accept;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW:0]     mul_sum, rem_sh, rem_diff;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

  // MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU are fully unsigned.
  always_comb begin
    is_div   = bus.in_op[2];
    a_signed = is_div ? !bus.in_op[0] : (bus.in_op[1:0] != 2'b11);
    b_signed = is_div ? !bus.in_op[0] : !bus.in_op[1];
    a_sign   = a_signed && bus.in_a[DW-1];
    b_sign   = b_signed && bus.in_b[DW-1];
    a_mag    = a_sign ? -bus.in_a : bus.in_a;
    b_mag    = b_sign ? -bus.in_b : bus.in_b;
    div_zero = is_div && (bus.in_b == '0);
    div_ovf  = is_div && !bus.in_op[0] && (bus.in_a == {1'b1, {(DW-1){1'b0}}}) &&
               (bus.in_b == '1);
  end

  assign bus.in_ready  = (state_q == IDLE) && !flush;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_rd    = rd_q;
  assign bus.res_data  = res_q;
  assign busy          = (state_q != IDLE);
  assign busy_rd       = busy ? rd_q : '0;
  assign accept        = bus.in_valid && bus.in_ready;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
    rem_fix  = a_neg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    a_neg_d = a_neg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.in_op;
          rd_d    = bus.in_rd;
          neg_d   = a_sign ^ b_sign;
          a_neg_d = a_sign;
          cnt_d   = '0;
          if (is_div) begin
            acc_d  = {{DW{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{DW{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          if (div_zero) begin
            res_d   = bus.in_op[1] ? bus.in_a : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = bus.in_op[1] ? '0 : bus.in_a;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          acc_d = rem_diff[DW] ? {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                               : {rem_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[DW-1:1]};
        end
        if (cnt_q == CW'(DW - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        case (op_q)
          3'b000:                 res_d = prod_fix[DW-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod_fix[2*DW-1:DW];
          3'b100, 3'b101:         res_d = quo_fix;
          default:                res_d = rem_fix;
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush kills whatever is in flight, including an unconsumed result.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit (RV32M) in the execute stage; produces rd writeback data for the register file's single write port through the writeback mux. Accepts one operation at a time over a valid/ready handshake, computes over DATAWIDTH+1 cycles, and holds the result until the writeback mux takes it. Exports busy/busy_rd so the hazard unit can stall readers of the pending rd.

Parameters:
DATAWIDTH, 32, operand/result width (XLEN)
ADDR_WIDTH, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  unit can accept (state IDLE and flush low)
in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_a  input  DATAWIDTH  rs1 value (multiplicand/dividend)
in_b  input  DATAWIDTH  rs2 value (multiplier/divisor)
in_rd  input  ADDR_WIDTH  destination register
flush  input  1  synchronous kill of the in-flight op (branch mispredict/trap)
res_valid  output  1  result available (state DONE)
res_ready  input  1  writeback mux consumes result
res_rd  output  ADDR_WIDTH  destination of result
res_data  output  DATAWIDTH  result
busy  output  1  state != IDLE
busy_rd  output  ADDR_WIDTH  rd of the in-flight op; 0 when idle

Behaviour:
- Reset (async, any state): state IDLE; res_valid 0, res_data 0, res_rd 0, busy 0, busy_rd 0, counter 0, all datapath registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1 unless flush. On in_valid&&in_ready, latch op, rd, operand signs, |a|/|b| (signed views per op; MULHSU: a signed, b unsigned), counter=0.
  - Normal: -> CALC.
  - Fast path -> DONE directly (result valid the cycle after accept): DIV/DIVU with b==0 (quotient all-ones, REM/REMU = a); DIV/REM with a==0x80000000 && b==all-ones (DIV = 0x80000000, REM = 0).
- CALC: one iteration per cycle, DATAWIDTH cycles (counter 0..DATAWIDTH-1), then -> FIX.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 2*DATAWIDTH product.
  - Divide: restoring, one quotient bit per cycle; remainder DATAWIDTH+1 bits wide.
- FIX: single cycle; apply sign correction; select result -> DONE.
  - Product negated iff the signs of the signed-view operands differ.
  - MUL: low half; MULH/MULHSU/MULHU: high half.
  - Quotient negated iff the signs differ; remainder takes the dividend's sign.
- DONE: res_valid=1, res_rd/res_data stable until res_ready. On res_ready -> IDLE; res_valid drops the next cycle. No accept in the same cycle as the result handshake (in_ready only in IDLE).
- Latency: accept edge E; res_valid first visible in the cycle after edge E+DATAWIDTH+1 (33 clocks for 32-bit). Fast path: visible after edge E.
- flush: synchronous, highest priority. Any state -> IDLE; result discarded; res_valid low next cycle. A flush in IDLE blocks acceptance that cycle. Flush in DONE with res_ready high: flush wins; the writeback mux must qualify with flush.
- rd==0: computed normally, presented with res_rd=0; the register file ignores it.
- busy_rd = latched rd while busy, else 0.
- Operands are latched at accept; in_a/in_b changes afterwards have no effect.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> res_data 0xFFFFFFEB, res_rd = in_rd, res_valid exactly 33 cycles after accept, in_ready low throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- Corner fast path: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with res_valid the cycle after accept.
- Stall and flush: hold res_ready low 10 cycles in DONE -> outputs stable, busy=1, busy_rd = rd. Separately, pulse flush at CALC cycle 10 -> IDLE next cycle, no res_valid; the next op is accepted and correct.
- Async rst asserted mid-CALC (between clock edges) -> busy, res_valid, and busy_rd immediately 0. After release, back-to-back ops with res_ready held high produce correct results in order.
